cla_slice_sequencer: RTL and testbench



---
 rtl/cla_slice_sequencer.sv | 111 +++++++++++
 tb/tb_cla_slice_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_slice_sequencer.sv
// cla_slice_sequencer
// Adds two OP_W-bit operands through one shared SLICE_W-bit adder slice,
// one slice per clock, LSB first, with a registered carry between slices.
// Operands arrive on a valid/ready input port; the OP_W+1-bit result
// {carry_out, sum} is held on a valid/ready output port until taken.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an operand pair; in_ready high
// ADD   | adding slice idx of the latched operands, one slice per clock
// DONE  | result valid on out_sum; waiting for out_ready
module cla_slice_sequencer #(
  parameter int SLICE_W    = 16,
  parameter int NUM_SLICES = 4,
  localparam int OP_W      = SLICE_W * NUM_SLICES
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_a,
  input  logic [OP_W-1:0] in_b,
  input  logic            in_cin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W:0]   out_sum,
  output logic            busy
);

  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [OP_W-1:0]    a_reg;
  logic [OP_W-1:0]    b_reg;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [OP_W:0]      sum_reg;
  logic [SLICE_W:0]   slice_t;

  // Shared slice adder: current slice of both operands plus the rippled carry.
  always_comb begin
    slice_t = {1'b0, a_reg[idx*SLICE_W +: SLICE_W]}
            + {1'b0, b_reg[idx*SLICE_W +: SLICE_W]}
            + {{SLICE_W{1'b0}}, carry};
  end

  // Sequencer FSM; handshake/busy flags are registered alongside the state
  // so every output comes straight from a flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum_reg   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            carry    <= in_cin;
            idx      <= '0;
            state    <= ADD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ADD: begin
          sum_reg[idx*SLICE_W +: SLICE_W] <= slice_t[SLICE_W-1:0];
          carry <= slice_t[SLICE_W];
          if (idx == LAST_IDX) begin
            sum_reg[OP_W] <= slice_t[SLICE_W];
            state         <= DONE;
            out_valid     <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_sum = sum_reg;

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Testbench for cla_slice_sequencer: directed cases with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_cla_slice_sequencer;

  localparam int SW   = 16;
  localparam int NS   = 4;
  localparam int OP_W = SW * NS;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [OP_W-1:0] in_a = '0;
  logic [OP_W-1:0] in_b = '0;
  logic            in_cin = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [OP_W:0]   out_sum;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  cla_slice_sequencer #(.SLICE_W(SW), .NUM_SLICES(NS)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [OP_W:0] act, input logic [OP_W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted pair is busy for NS add cycles,
  // then its arithmetic sum is offered until out_ready is seen.
  logic [OP_W:0] exp_q[$];
  int            m_left;
  bit            m_done;
  logic [OP_W:0] m_result;
  logic [OP_W:0] m_out;
  int            m_accepts;
  int            n_deliv;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_left = 0; m_done = 0; m_result = '0; m_out = '0;
      exp_q.delete();
    end else if (m_done) begin
      if (out_ready) m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        m_out  = m_result;
      end
    end else if (in_valid) begin
      m_result = {1'b0, in_a} + {1'b0, in_b} + {{OP_W{1'b0}}, in_cin};
      exp_q.push_back(m_result);
      m_left = NS;
      m_accepts++;
    end
  end

  // Compare process: mid-cycle, DUT outputs against the model every cycle.
  always @(negedge clock) begin
    if (!reset) begin
      logic exp_idle;
      exp_idle = (m_left == 0) && !m_done;
      chk("in_ready",  {{OP_W{1'b0}}, in_ready},  {{OP_W{1'b0}}, exp_idle});
      chk("out_valid", {{OP_W{1'b0}}, out_valid}, {{OP_W{1'b0}}, m_done});
      chk("busy",      {{OP_W{1'b0}}, busy},      {{OP_W{1'b0}}, !exp_idle});
      if (m_left == 0) chk("out_sum_model", out_sum, m_out);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_extra_result", 1, 0);
        end else begin
          chk("scoreboard_sum", out_sum, exp_q[0]);
          void'(exp_q.pop_front());
          n_deliv++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_out_valid(input string name, input int maxc);
    int n = 0;
    while (!out_valid && n < maxc) begin
      tick();
      n++;
    end
    chk(name, {{OP_W{1'b0}}, out_valid}, 1);
  endtask

  function automatic logic [OP_W-1:0] rnd_op();
    logic [OP_W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '1;
      1:       v = '0;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    logic [OP_W:0] lit;
    logic [OP_W:0] held;
    int acc_cyc[5];
    int n;
    int target;

    m_accepts = 0;
    n_deliv   = 0;

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_in_ready",  {{OP_W{1'b0}}, in_ready},  1);
    chk("reset_out_valid", {{OP_W{1'b0}}, out_valid}, 0);
    chk("reset_busy",      {{OP_W{1'b0}}, busy},      0);
    chk("reset_out_sum",   out_sum, 0);

    // Basic add with latency: accept edge then NS add edges
    in_a = 64'h5; in_b = 64'h3; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < NS; i++) begin
      tick();
      chk("basic_busy", {{OP_W{1'b0}}, busy}, 1);
      chk("basic_not_yet_valid", {{OP_W{1'b0}}, out_valid}, 0);
    end
    tick();
    chk("basic_valid_at_latency", {{OP_W{1'b0}}, out_valid}, 1);
    chk("basic_sum", out_sum, 65'h8);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("basic_back_idle", {{OP_W{1'b0}}, in_ready}, 1);

    // Full carry ripple
    in_a = '1; in_b = '0; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out_valid("ripple1_wait", 20);
    lit = 65'h1_0000_0000_0000_0000;
    chk("ripple1_sum", out_sum, lit);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // All ones plus carry, then held under backpressure
    in_a = '1; in_b = '1; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out_valid("ripple2_wait", 20);
    lit = 65'h1_FFFF_FFFF_FFFF_FFFF;
    chk("ripple2_sum", out_sum, lit);
    held = out_sum;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      tick();
      chk("bp_out_valid", {{OP_W{1'b0}}, out_valid}, 1);
      chk("bp_in_ready",  {{OP_W{1'b0}}, in_ready},  0);
      chk("bp_sum_stable", out_sum, lit);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_idle", {{OP_W{1'b0}}, in_ready}, 1);
    chk("bp_release_valid", {{OP_W{1'b0}}, out_valid}, 0);
    chk("bp_sum_kept", out_sum, held);

    // Reset mid-ADD while the third slice is being added
    in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h1111_1111_1111_1111; in_cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_out_valid", {{OP_W{1'b0}}, out_valid}, 0);
    chk("rst_async_busy",      {{OP_W{1'b0}}, busy},      0);
    chk("rst_async_out_sum",   out_sum, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_in_ready_after", {{OP_W{1'b0}}, in_ready}, 1);
    in_a = 64'h1; in_b = 64'h1; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out_valid("rst_followup_wait", 20);
    chk("rst_followup_sum", out_sum, 65'h2);
    out_ready = 1'b1; tick();

    // Back-to-back with in_valid and out_ready held high
    in_valid = 1'b1;
    in_a = rnd_op(); in_b = rnd_op(); in_cin = 1'($urandom_range(0, 1));
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!in_ready && n < 20) begin
        tick();
        n++;
      end
      chk("b2b_ready", {{OP_W{1'b0}}, in_ready}, 1);
      acc_cyc[k] = cyc;
      tick();
      in_a = rnd_op(); in_b = rnd_op(); in_cin = 1'($urandom_range(0, 1));
      if (k > 0) chk("b2b_interval", (OP_W+1)'(acc_cyc[k] - acc_cyc[k-1]), (OP_W+1)'(NS + 2));
    end
    in_valid = 1'b0;
    repeat (NS + 3) tick();
    chk("b2b_drained", (OP_W+1)'(exp_q.size()), 0);

    // Random traffic with random stalls on both sides
    target = m_accepts + 1000;
    n = 0;
    while (m_accepts < target && n < 40000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_a = rnd_op(); in_b = rnd_op(); in_cin = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("rand_all_accepted", (OP_W+1)'(m_accepts >= target), 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 50) begin
      tick();
      n++;
    end
    chk("rand_no_lost_results", (OP_W+1)'(exp_q.size()), 0);
    chk("rand_idle_at_end", {{OP_W{1'b0}}, in_ready}, 1);
    chk("rand_deliv_count", (OP_W+1)'(n_deliv), (OP_W+1)'(m_accepts - 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
